// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a core request port and a
// single-ported word-wide data memory with combinational read data.
// Handles RV32I LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores are done as a
// read-modify-write (read in ACCESS, write the merged word in WRITE).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_funct3       1 = store; RV32I size/sign code
//   req_addr, req_wdata      byte address; LSB-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               formatted load data (0 after stores/errors)
//   resp_err                 misaligned or illegal funct3, valid with resp_valid
//   mem_wr_en, mem_addr      memory write enable; word-aligned byte address
//   mem_wr_data              full word to write
//   mem_rd_data              combinational read data for mem_addr
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                state_q, state_n;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_bad;
  logic                  is_sw;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] merged_n;

  // Legality of the incoming request: funct3 decode plus natural alignment.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = |req_addr[1:0];
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  assign is_sw = we_q && (f3_q[1:0] == 2'b10);

  // Load lane selection/extension and store lane merge, both from the
  // memory word currently presented on mem_rd_data during ACCESS.
  always_comb begin
    byte_lane = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
    half_lane = mem_rd_data[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_fmt = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      3'b001:  load_fmt = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_fmt = mem_rd_data;
    endcase
    merged_n = mem_rd_data;
    if (f3_q[1:0] == 2'b00) begin
      merged_n[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_n[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Next state and outputs.
  always_comb begin
    state_n     = state_q;
    req_ready   = (state_q == IDLE);
    accept      = req_valid && (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    resp_err    = (state_q == RESP) && err_q;
    resp_rdata  = rdata_q;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_n = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (is_sw) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = wdata_q;
        end
        state_n = (we_q && !is_sw) ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wr_en   = 1'b1;
        mem_wr_data = merged_q;
        state_n     = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A reset edge landing mid-store must not commit a write.
    if (rst) mem_wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_bad;
            if (req_bad) rdata_q <= '0;
          end
        end
        ACCESS: begin
          if (we_q) begin
            rdata_q  <= '0;
            merged_q <= merged_n;
          end else begin
            rdata_q <= load_fmt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model with a preload port.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign mem_rd_data = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wr_data;
  end

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int acc; int dly; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t mr;
  wr_t   mw;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: compares every response and every memory write against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_q.size() > 0) chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (resp_valid) begin
        if (resp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          mr = resp_q.pop_front();
          chk("resp_err", 32'(resp_err), 32'(mr.err));
          chk("resp_rdata", resp_rdata, mr.rdata);
          chk("resp_latency", 32'(cyc - mr.acc + 1), 32'(mr.lat));
        end
      end
      if (mem_wr_en) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          mw = wr_q.pop_front();
          chk("wr_addr", mem_addr, mw.addr);
          chk("wr_data", mem_wr_data, mw.data);
          chk("wr_timing", 32'(cyc - mw.acc), 32'(mw.dly));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input logic e_wr, input logic [31:0] e_wd,
                       input bit hold, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    resp_q.push_back('{e_err, e_rd, acc, e_lat});
    if (e_wr) wr_q.push_back('{addr & ~32'h3, e_wd, acc, e_lat - 2});
    if (!hold) begin
      // Garbage on the request port while busy must be ignored.
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_funct3 = 3'b111;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((resp_q.size() > 0 || wr_q.size() > 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (resp_q.size() > 0 || wr_q.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    resp_q.delete();
    wr_q.delete();
    @(negedge clk);
  endtask

  int a1, a2;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_idx = 6'(i);
      pl_data = (i == 4) ? 32'h8000_FF7F : (i == 8) ? 32'h1122_3344 : 32'h0;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // Loads with sign/zero extension from word 0x10 = 0x8000_FF7F.
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h0000_007F, 2, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h0000_00FF, 2, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_8000, 2, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_8000, 2, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8000_FF7F, 2, 1'b0, 32'h0, 1'b0, a1);
    drain();

    // Sub-word stores into word 0x20 = 0x1122_3344 (upper wdata bits ignored).
    issue(1'b1, 3'b000, 32'h21, 32'h1234_56AB, 1'b0, 32'h0, 3, 1'b1, 32'h1122_AB44, 1'b0, a1);
    issue(1'b1, 3'b001, 32'h22, 32'h5555_BEEF, 1'b0, 32'h0, 3, 1'b1, 32'hBEEF_AB44, 1'b0, a1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hBEEF_AB44, 2, 1'b0, 32'h0, 1'b0, a1);
    drain();

    // Word store then read back.
    issue(1'b1, 3'b010, 32'h04, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, a1);
    issue(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1'b0, a1);
    // Errors: misaligned word/halfword, illegal load and store funct3.
    issue(1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b1, 3'b001, 32'h03, 32'h1234, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1'b0, a1);
    issue(1'b1, 3'b100, 32'h00, 32'hFF, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1'b0, a1);
    drain();

    // Reset while an SB sits in WRITE: no write, no response.
    issue(1'b1, 3'b000, 32'h10, 32'h55, 1'b0, 32'h0, 3, 1'b0, 32'h0, 1'b0, a1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    resp_q.delete();
    wr_q.delete();
    #1;
    chk("wr_en_forced_low_in_rst", 32'(mem_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mem_unchanged_after_rst", mem[4], 32'h8000_FF7F);
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("rdata_after_rst", resp_rdata, 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back with req_valid held high.
    issue(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1'b1, a1);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h0000_007F, 2, 1'b0, 32'h0, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
